// File: rtl/mmio_pkg.sv
// Shared constants for bus peripherals: register offsets within a window and idle read value.
package mmio_pkg;

    localparam logic [2:0]  OFF_OUT    = 3'd0;
    localparam logic [2:0]  OFF_IN     = 3'd1;
    localparam logic [2:0]  OFF_SET    = 3'd2;
    localparam logic [2:0]  OFF_CLR    = 3'd3;
    localparam logic [2:0]  OFF_STAT   = 3'd4;
    localparam logic [2:0]  OFF_IEN    = 3'd5;

    localparam logic [15:0] DFLT_RDATA = 16'h8585;

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchroniser for asynchronous pin inputs; clears to zero on synchronous reset.
module gpio_sync #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/mmio_gpio_bank.sv
// Memory-mapped GPIO bank: output latch with set/clear, synchronised inputs,
// sticky rising-edge status (W1C) and a maskable level interrupt.
module mmio_gpio_bank #(
    parameter logic [15:0]       BASE_ADDR  = 16'hC000,
    parameter int unsigned       DATA_W     = 16,
    parameter int unsigned       NUM_OUT    = 10,
    parameter int unsigned       NUM_IN     = 10,
    parameter logic [DATA_W-1:0] DFLT_RDATA = DATA_W'(mmio_pkg::DFLT_RDATA)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        addr,
    input  logic               we,
    input  logic               re,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata,
    output logic [NUM_OUT-1:0] gpio_out,
    input  logic [NUM_IN-1:0]  gpio_in,
    output logic               irq
);

    import mmio_pkg::*;

    if (BASE_ADDR[2:0] != 3'b000) begin : g_bad_base
        $error("mmio_gpio_bank: BASE_ADDR must be 8-word aligned");
    end
    if (NUM_OUT < 1 || NUM_OUT > DATA_W) begin : g_bad_num_out
        $error("mmio_gpio_bank: NUM_OUT must be in 1..DATA_W");
    end
    if (NUM_IN < 1 || NUM_IN > DATA_W) begin : g_bad_num_in
        $error("mmio_gpio_bank: NUM_IN must be in 1..DATA_W");
    end

    logic              sel;
    logic [2:0]        off;
    logic              wr_en;
    logic              rd_en;

    logic [NUM_OUT-1:0] out_q, out_d;
    logic [NUM_IN-1:0]  ien_q, ien_d;
    logic [NUM_IN-1:0]  stat_q, stat_d;
    logic [NUM_IN-1:0]  stat_clr;
    logic [NUM_IN-1:0]  s2;
    logic [NUM_IN-1:0]  s3_q;
    logic [NUM_IN-1:0]  rise;
    logic [1:0]         arm_cnt_q;
    logic               armed;
    logic               unused_wdata;

    assign sel   = (addr[15:3] == BASE_ADDR[15:3]);
    assign off   = addr[2:0];
    assign wr_en = sel & we;
    assign rd_en = sel & re;

    // Only the low NUM_x bits of wdata are meaningful.
    assign unused_wdata = ^wdata;

    gpio_sync #(
        .W (NUM_IN)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gpio_in),
        .q   (s2)
    );

    // Pins already high at reset release would otherwise look like rising edges.
    assign armed = (arm_cnt_q == 2'd3);
    assign rise  = s2 & ~s3_q & {NUM_IN{armed}};

    always_comb begin
        out_d    = out_q;
        ien_d    = ien_q;
        stat_clr = '0;
        if (wr_en) begin
            case (off)
                OFF_OUT:  out_d    = wdata[NUM_OUT-1:0];
                OFF_SET:  out_d    = out_q | wdata[NUM_OUT-1:0];
                OFF_CLR:  out_d    = out_q & ~wdata[NUM_OUT-1:0];
                OFF_STAT: stat_clr = wdata[NUM_IN-1:0];
                OFF_IEN:  ien_d    = wdata[NUM_IN-1:0];
                default:  ;
            endcase
        end
        // A new edge on a bit being cleared keeps that bit set.
        stat_d = (stat_q & ~stat_clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            ien_q     <= '0;
            stat_q    <= '0;
            s3_q      <= '0;
            arm_cnt_q <= 2'd0;
        end else begin
            out_q  <= out_d;
            ien_q  <= ien_d;
            stat_q <= stat_d;
            s3_q   <= s2;
            if (!armed) begin
                arm_cnt_q <= arm_cnt_q + 2'd1;
            end
        end
    end

    always_comb begin
        rdata = DFLT_RDATA;
        if (rd_en) begin
            case (off)
                OFF_OUT:  rdata = DATA_W'(out_q);
                OFF_IN:   rdata = DATA_W'(s2);
                OFF_STAT: rdata = DATA_W'(stat_q);
                OFF_IEN:  rdata = DATA_W'(ien_q);
                default:  rdata = DFLT_RDATA;
            endcase
        end
    end

    assign gpio_out = out_q;
    assign irq      = |(stat_q & ien_q);

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// Bench for mmio_gpio_bank: directed register-map scenarios, then random traffic vs a pin-history model.
module tb_mmio_gpio_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = 16'h0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [15:0] wdata = 16'h0;
    logic [15:0] rdata;
    logic [9:0]  gpio_out;
    logic [9:0]  gpio_in = 10'h0;
    logic        irq;

    int tests = 0;
    int fails = 0;

    // Model: register contents plus the raw pin value captured at each clock edge.
    logic [9:0] m_out  = '0;
    logic [9:0] m_ien  = '0;
    logic [9:0] m_stat = '0;
    logic [9:0] pin_hist[$] = '{10'h0, 10'h0, 10'h0};
    int         m_rel  = 0;

    always #5 clk = ~clk;

    mmio_gpio_bank dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .we       (we),
        .re       (re),
        .wdata    (wdata),
        .rdata    (rdata),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in),
        .irq      (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_rdata();
        if (!(re && addr[15:3] == 13'h1800)) return 16'h8585;
        case (addr[2:0])
            3'd0:    return {6'h0, m_out};
            3'd1:    return {6'h0, pin_hist[$-1]};
            3'd4:    return {6'h0, m_stat};
            3'd5:    return {6'h0, m_ien};
            default: return 16'h8585;
        endcase
    endfunction

    // Advance the model with the inputs present at the coming edge, then cross that edge.
    task automatic tick();
        logic [9:0] rise;
        logic [9:0] clr;
        if (rst) begin
            m_out    = '0;
            m_ien    = '0;
            m_stat   = '0;
            m_rel    = 0;
            pin_hist = '{10'h0, 10'h0, 10'h0};
        end else begin
            rise = (m_rel >= 3) ? (pin_hist[$-1] & ~pin_hist[$-2]) : 10'h0;
            clr  = '0;
            if (we && addr[15:3] == 13'h1800) begin
                case (addr[2:0])
                    3'd0: m_out = wdata[9:0];
                    3'd2: m_out = m_out | wdata[9:0];
                    3'd3: m_out = m_out & ~wdata[9:0];
                    3'd4: clr   = wdata[9:0];
                    3'd5: m_ien = wdata[9:0];
                    default: ;
                endcase
            end
            m_stat = (m_stat & ~clr) | rise;
            pin_hist.push_back(gpio_in);
            void'(pin_hist.pop_front());
            if (m_rel < 3) m_rel++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        re    = 1'b0;
        tick();
        we    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
        addr = a;
        re   = 1'b1;
        we   = 1'b0;
        #1;
        chk(tag, rdata, exp);
        re   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        rd("rst_out", 16'hC000, 16'h0000);
        rd("rst_in", 16'hC001, 16'h0000);
        rd("rst_stat", 16'hC004, 16'h0000);
        chk("rst_irq", irq, 0);
        rd("unmapped6", 16'hC006, 16'h8585);
        rd("unmapped7", 16'hC007, 16'h8585);
        rd("outside", 16'h1234, 16'h8585);

        wr(16'hC000, 16'h03FF);
        wr(16'hC003, 16'h0005);
        wr(16'hC002, 16'h0400);
        chk("setclr_pins", gpio_out, 10'h3FA);
        rd("setclr_rb", 16'hC000, 16'h03FA);

        gpio_in = 10'h201;
        tick();
        rd("in_lat1", 16'hC001, 16'h0000);
        tick();
        rd("in_lat2", 16'hC001, 16'h0201);
        rd("stat_early", 16'hC004, 16'h0000);
        tick();
        rd("stat_set", 16'hC004, 16'h0201);
        chk("irq_masked", irq, 0);
        wr(16'hC005, 16'h0001);
        chk("irq_en", irq, 1);
        gpio_in = 10'h000;
        repeat (4) tick();
        rd("fall_keep", 16'hC004, 16'h0201);

        gpio_in = 10'h001;
        tick();
        tick();
        wr(16'hC004, 16'h0001);
        rd("w1c_race", 16'hC004, 16'h0201);
        wr(16'hC004, 16'h0201);
        rd("w1c_all", 16'hC004, 16'h0000);
        chk("irq_clr", irq, 0);

        gpio_in = 10'h3FF;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wr(16'hC005, 16'h03FF);
        for (int i = 0; i < 9; i++) begin
            tick();
            rd("arm_stat", 16'hC004, 16'h0000);
            chk("arm_irq", irq, 0);
        end
        rd("arm_in", 16'hC001, 16'h03FF);

        wr(16'hC000, 16'h00AA);
        chk("pre_rst_out", gpio_out, 10'h0AA);
        addr  = 16'hC000;
        wdata = 16'h0155;
        we    = 1'b1;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
        we    = 1'b0;
        chk("rst_wins", gpio_out, 10'h000);
        addr = 16'hC001;
        re   = 1'b0;
        #1;
        chk("re_low", rdata, 16'h8585);

        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(63) == 0);
            we    = $urandom_range(1) == 1;
            re    = $urandom_range(1) == 1;
            addr  = ($urandom_range(7) == 0) ? 16'($urandom) : (16'hC000 | 16'($urandom_range(7)));
            wdata = 16'($urandom);
            if ($urandom_range(3) == 0) gpio_in = 10'($urandom);
            #1;
            chk("rnd_rdata", rdata, exp_rdata());
            chk("rnd_out", gpio_out, m_out);
            chk("rnd_irq", irq, |(m_stat & m_ien));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
